gs_elim_array: RTL and testbench
================================

GS_ELIM_ARRAY -- requirements
Module: gs_elim_array

Interface
REQ-001 Parameter l, default 4: row width in bits over GF(2); l >= 2.
REQ-002 Parameter d, default 2: number of pivot stages, i.e. pipeline depth; 1 <= d <= l.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_b  input  1  asynchronous, active-low reset.
REQ-005 SA_mode  input  1  0 = eliminate (pivot capture enabled); 1 = reduce-only (pivots frozen).
REQ-006 SA_start  input  1  one-cycle pulse; begins a pass.
REQ-007 SA_swap  input  1  level; each high cycle shifts the pivot chain out by one row.
REQ-008 row_in  input  l  row read from memory.
REQ-009 row_in_valid  input  1  row_in is a valid row this cycle.
REQ-010 SA_dout  output  l  row result, driven to the controller's SA_din.
REQ-011 dout_valid  output  1  SA_dout valid this cycle.
REQ-012 pivot_cnt  output  clog2(d+1)  number of currently held pivots.

Function
REQ-013 Stage j (0..d-1) holds pivot register P_j[l-1:0], pivot column c_j[clog2(l)-1:0] and valid flag v_j.
REQ-014 SA_start clears every v_j, P_j and c_j, and every stage data-valid, in the cycle after the pulse; a row_in_valid in the SA_start cycle is discarded.
REQ-015 Rows enter stage 0 registered; each stage adds exactly one cycle: row accepted at cycle t appears on SA_dout with dout_valid at cycle t+d.
REQ-016 Stage j, valid row R, v_j=1: if R[c_j]=1 forward R xor P_j, else forward R unchanged.
REQ-017 Stage j, valid row R, v_j=0, SA_mode=0, R nonzero: load P_j<=R, c_j<=index of highest set bit of R, v_j<=1; forward an all-zero valid row.
REQ-018 Stage j, v_j=0, with SA_mode=1 or R all-zero: forward R unchanged; no capture.
REQ-019 Invalid slots propagate as invalid; no stage state changes on an invalid slot.
REQ-020 SA_swap high: SA_dout<=P_{d-1}, dout_valid<=v_{d-1}; for j>=1, {P_j,c_j,v_j}<={P_{j-1},c_{j-1},v_{j-1}}; stage 0 loads zero with v_0=0; d consecutive swap cycles emit all pivots in order P_{d-1}..P_0.
REQ-021 SA_swap has priority: row_in_valid in a swap cycle is ignored; data rows already in the pipeline are dropped (bench and controller guarantee the pipeline is drained first).
REQ-022 SA_swap and SA_start in the same cycle: SA_start wins; swap ignored.
REQ-023 pivot_cnt = count of v_j set, updated combinationally from registers.
REQ-024 Capture after xor: a stage sees the row already reduced by all upstream stages; all captured pivots have distinct c_j.
REQ-025 SA_dout holds its last value when dout_valid=0.

Reset
REQ-026 rst_b low asynchronously clears all P_j, c_j, v_j, stage data, SA_dout=0, dout_valid=0, pivot_cnt=0.
REQ-027 Reset mid-pass or mid-swap aborts without residue; the first post-reset SA_start behaves as from power-up.

Verification
REQ-028 l=4,d=2: SA_start, then rows 1010,0110,1100,0001 on consecutive cycles, SA_mode=0 -> P_0=1010 (c=3), P_1=0110 (c=2); outputs at t+2: 0000,0000,0000,0001; pivot_cnt=2.
REQ-029 After REQ-028, SA_swap high 2 cycles -> SA_dout 0110 then 1010, dout_valid 1,1; pivot_cnt=0.
REQ-030 SA_mode=1 after capture of P_0=1000: row 1011 -> 0011 at latency d; v_1 stays 0.
REQ-031 All-zero rows streamed -> no capture, outputs 0000 valid, pivot_cnt=0.
REQ-032 Assert rst_b=0 during the 2nd row of REQ-028 -> all outputs 0 immediately; no valid output afterwards until new rows arrive.
REQ-033 SA_start and SA_swap same cycle with pivot_cnt=2 -> pivots cleared, no valid output.

Source files
------------

// File: rtl/gs_elim_array.sv
// Systolic GF(2) Gaussian-elimination array: d pivot stages, one cycle each.
// Rows are reduced against held pivots; unmatched nonzero rows become pivots.
module gs_elim_array #(
    parameter int l = 4,
    parameter int d = 2
) (
    input  logic                     clk,
    input  logic                     rst_b,
    input  logic                     SA_mode,
    input  logic                     SA_start,
    input  logic                     SA_swap,
    input  logic [l-1:0]             row_in,
    input  logic                     row_in_valid,
    output logic [l-1:0]             SA_dout,
    output logic                     dout_valid,
    output logic [$clog2(d+1)-1:0]   pivot_cnt
);

    localparam int CW = $clog2(l);
    localparam int PW = $clog2(d+1);

    logic [l-1:0]  p_q   [d];
    logic [CW-1:0] c_q   [d];
    logic [d-1:0]  v_q;
    logic [l-1:0]  dat_q [d];
    logic [d-1:0]  val_q;

    logic [l-1:0]  in_r  [d];
    logic [d-1:0]  in_v;
    logic [l-1:0]  fwd   [d];
    logic [d-1:0]  cap;

    function automatic logic [CW-1:0] msb_idx(input logic [l-1:0] r);
        msb_idx = '0;
        for (int i = 0; i < l; i++) begin
            if (r[i]) msb_idx = CW'(i);
        end
    endfunction

    always_comb begin
        in_r[0] = row_in;
        in_v[0] = row_in_valid;
        for (int j = 1; j < d; j++) begin
            in_r[j] = dat_q[j-1];
            in_v[j] = val_q[j-1];
        end
    end

    // Capture decision ignores slot validity; the register block gates it.
    always_comb begin
        cap = '0;
        for (int j = 0; j < d; j++) begin
            fwd[j] = in_r[j];
            if (v_q[j]) begin
                if (in_r[j][c_q[j]]) fwd[j] = in_r[j] ^ p_q[j];
            end else if (!SA_mode && (in_r[j] != '0)) begin
                cap[j] = 1'b1;
                fwd[j] = '0;
            end
        end
    end

    always_comb begin
        pivot_cnt = '0;
        for (int j = 0; j < d; j++) begin
            pivot_cnt = pivot_cnt + PW'(v_q[j]);
        end
    end

    assign SA_dout    = dat_q[d-1];
    assign dout_valid = val_q[d-1];

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int j = 0; j < d; j++) begin
                p_q[j]   <= '0;
                c_q[j]   <= '0;
                dat_q[j] <= '0;
            end
            v_q   <= '0;
            val_q <= '0;
        end else if (SA_start) begin
            for (int j = 0; j < d; j++) begin
                p_q[j] <= '0;
                c_q[j] <= '0;
            end
            v_q   <= '0;
            val_q <= '0;
        end else if (SA_swap) begin
            // Shift the pivot chain toward the output; in-flight rows drop.
            val_q          <= '0;
            val_q[d-1]     <= v_q[d-1];
            dat_q[d-1]     <= p_q[d-1];
            p_q[0]         <= '0;
            c_q[0]         <= '0;
            v_q[0]         <= 1'b0;
            for (int j = 1; j < d; j++) begin
                p_q[j] <= p_q[j-1];
                c_q[j] <= c_q[j-1];
                v_q[j] <= v_q[j-1];
            end
        end else begin
            val_q <= in_v;
            for (int j = 0; j < d; j++) begin
                if (in_v[j]) begin
                    dat_q[j] <= fwd[j];
                    if (cap[j]) begin
                        p_q[j] <= in_r[j];
                        c_q[j] <= msb_idx(in_r[j]);
                        v_q[j] <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_gs_elim_array.sv
// Directed vector bench for gs_elim_array (l=4, d=2).
module tb_gs_elim_array;

    logic       clk = 1'b0;
    logic       rst_b;
    logic       SA_mode, SA_start, SA_swap;
    logic [3:0] row_in;
    logic       row_in_valid;
    logic [3:0] SA_dout;
    logic       dout_valid;
    logic [1:0] pivot_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    gs_elim_array #(.l(4), .d(2)) dut (
        .clk(clk), .rst_b(rst_b), .SA_mode(SA_mode),
        .SA_start(SA_start), .SA_swap(SA_swap),
        .row_in(row_in), .row_in_valid(row_in_valid),
        .SA_dout(SA_dout), .dout_valid(dout_valid),
        .pivot_cnt(pivot_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       start;
        logic       swap;
        logic       mode;
        logic       vld;
        logic [3:0] row;
        logic       edv;
        logic [3:0] edout;
        logic [1:0] ecnt;
    } vec_t;

    localparam int NV = 33;
    vec_t tv [NV];

    task automatic chk(input string nm, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input int idx,
                             input logic edv, input logic [3:0] edout,
                             input logic [1:0] ecnt);
        chk({tag, ".dout_valid"}, idx, 32'(dout_valid), 32'(edv));
        chk({tag, ".SA_dout"},    idx, 32'(SA_dout),    32'(edout));
        chk({tag, ".pivot_cnt"},  idx, 32'(pivot_cnt),  32'(ecnt));
    endtask

    task automatic step(input logic st, input logic sw, input logic md,
                        input logic vl, input logic [3:0] r);
        SA_start     = st;
        SA_swap      = sw;
        SA_mode      = md;
        row_in_valid = vl;
        row_in       = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //          start swap mode vld row      dv dout     cnt
        tv[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0};
        tv[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'b1010, 1'b0, 4'b0000, 2'd1};
        tv[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'b0110, 1'b1, 4'b0000, 2'd1};
        tv[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'b1100, 1'b1, 4'b0000, 2'd2};
        tv[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'b0001, 1'b1, 4'b0000, 2'd2};
        tv[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 4'b0001, 2'd2};
        tv[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0001, 2'd2};
        tv[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, 4'b0110, 2'd1};
        tv[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, 4'b1010, 2'd0};
        tv[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b1010, 2'd0};
        tv[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b1010, 2'd0};
        tv[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 4'b1010, 2'd0};
        tv[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b1, 4'b0000, 2'd0};
        tv[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b1, 4'b0000, 2'd0};
        tv[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 4'b0000, 2'd0};
        tv[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0};
        tv[16] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0};
        tv[17] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'b1000, 1'b0, 4'b0000, 2'd1};
        tv[18] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'b1011, 1'b1, 4'b0000, 2'd1};
        tv[19] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b1, 4'b0011, 2'd1};
        tv[20] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0011, 2'd1};
        tv[21] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0011, 2'd0};
        tv[22] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'b0011, 1'b0, 4'b0011, 2'd1};
        tv[23] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'b0100, 1'b1, 4'b0000, 2'd1};
        tv[24] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 4'b0000, 2'd2};
        tv[25] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 2'd2};
        tv[26] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0};
        tv[27] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0};
        tv[28] = '{1'b1, 1'b0, 1'b0, 1'b1, 4'b1111, 1'b0, 4'b0000, 2'd0};
        tv[29] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0};
        tv[30] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0};
        tv[31] = '{1'b0, 1'b1, 1'b0, 1'b1, 4'b1000, 1'b0, 4'b0000, 2'd0};
        tv[32] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0};

        rst_b        = 1'b0;
        SA_mode      = 1'b0;
        SA_start     = 1'b0;
        SA_swap      = 1'b0;
        row_in       = 4'b0000;
        row_in_valid = 1'b0;
        #1;
        check_out("reset", 0, 1'b0, 4'b0000, 2'd0);
        @(negedge clk);
        @(negedge clk);
        rst_b = 1'b1;

        for (int i = 0; i < NV; i++) begin
            step(tv[i].start, tv[i].swap, tv[i].mode, tv[i].vld, tv[i].row);
            check_out("vec", i, tv[i].edv, tv[i].edout, tv[i].ecnt);
        end

        // Make SA_dout nonzero, then hold one pivot before a mid-pass reset.
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
        step(1'b0, 1'b0, 1'b0, 1'b1, 4'b1010);
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'b0000);
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'b0000);
        check_out("preswap", 0, 1'b1, 4'b1010, 2'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
        step(1'b0, 1'b0, 1'b0, 1'b1, 4'b1010);
        check_out("prerst", 0, 1'b0, 4'b1010, 2'd1);

        SA_start     = 1'b0;
        SA_swap      = 1'b0;
        row_in_valid = 1'b1;
        row_in       = 4'b0110;
        #2;
        rst_b = 1'b0;
        #1;
        check_out("async_rst", 0, 1'b0, 4'b0000, 2'd0);
        row_in_valid = 1'b0;
        row_in       = 4'b0000;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
            check_out("postrst_idle", i, 1'b0, 4'b0000, 2'd0);
        end

        step(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
        check_out("fresh", 0, 1'b0, 4'b0000, 2'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 4'b1100);
        check_out("fresh", 1, 1'b0, 4'b0000, 2'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 4'b0100);
        check_out("fresh", 2, 1'b1, 4'b0000, 2'd1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
        check_out("fresh", 3, 1'b1, 4'b0000, 2'd2);
        step(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
        check_out("fresh", 4, 1'b0, 4'b0000, 2'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
